// File: rtl/ups_pkg.sv
// Shared types and constants for the UPS DAC serial transmit path.
package ups_pkg;
  localparam int UPS_DAC_W = 16;

  typedef enum logic [2:0] {
    DTX_IDLE,
    DTX_SETUP,
    DTX_SHIFT,
    DTX_HOLD,
    DTX_GAP
  } dac_tx_state_t;
endpackage

// File: rtl/ups_dac_spi_tx_if.sv
// Controller-to-DAC transmit bundle; dac_ldac_n exists only when UPS_DAC_LDAC_EN is defined.
interface ups_dac_spi_tx_if
  import ups_pkg::*;
#(
  parameter int DATA_W = UPS_DAC_W,
  parameter int DROP_W = 8
);
  logic [DATA_W-1:0] dac;
  logic              dac_dv;
  logic              busy;
  logic              done;
  logic [DROP_W-1:0] drop_cnt;
  logic              dac_sclk;
  logic              dac_cs_n;
  logic              dac_mosi;
`ifdef UPS_DAC_LDAC_EN
  logic              dac_ldac_n;

  modport master (output dac, dac_dv,
                  input  busy, done, drop_cnt, dac_sclk, dac_cs_n, dac_mosi, dac_ldac_n);
  modport slave  (input  dac, dac_dv,
                  output busy, done, drop_cnt, dac_sclk, dac_cs_n, dac_mosi, dac_ldac_n);
`else
  modport master (output dac, dac_dv,
                  input  busy, done, drop_cnt, dac_sclk, dac_cs_n, dac_mosi);
  modport slave  (input  dac, dac_dv,
                  output busy, done, drop_cnt, dac_sclk, dac_cs_n, dac_mosi);
`endif
endinterface

// File: rtl/ups_sclk_tick.sv
// Half-period timer: tick marks the last cycle of each CLK_DIV-long phase; restart reloads it.
// With UPS_DAC_LDAC_EN, extra stretches the phase begun by restart by one cycle.
module ups_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
`ifdef UPS_DAC_LDAC_EN
  input  logic extra,
  output logic two_left,
`endif
  output logic tick
);
  logic [7:0] cnt;
  logic [7:0] reload;

`ifdef UPS_DAC_LDAC_EN
  assign reload   = 8'(CLK_DIV - 1) + {7'd0, extra};
  assign two_left = (cnt == 8'd2);
`else
  assign reload   = 8'(CLK_DIV - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst)          cnt <= 8'(CLK_DIV - 1);
    else if (restart) cnt <= reload;
    else              cnt <= cnt - 8'd1;
  end

  assign tick = (cnt == 8'd0);
endmodule

// File: rtl/ups_dac_spi_tx.sv
// SPI mode-0 DAC transmitter with one latest-wins pending word and a saturating drop counter.
// UPS_DAC_LDAC_EN adds dac_ldac_n and stretches the inter-frame gap by one cycle.
module ups_dac_spi_tx
  import ups_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = UPS_DAC_W,
  parameter int DROP_W  = 8
) (
  input logic             clk,
  input logic             rst,
  ups_dac_spi_tx_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  dac_tx_state_t     state;
  logic [DATA_W-2:0] rest;
  logic [DATA_W-1:0] pend, launch_word;
  logic              pend_vld;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DROP_W-1:0] drop_cnt;
  logic              busy, done, sclk, cs_n, mosi;
  logic              tick, restart, launch, launch_slot;

  // Counter is held in reload while idle so SETUP always gets a full half-period.
  assign restart     = tick || (state == DTX_IDLE);
  assign launch_slot = (state == DTX_GAP) && tick;

`ifdef UPS_DAC_LDAC_EN
  logic extra, two_left, ldac_n;
  assign extra          = (state == DTX_HOLD);
  assign bus.dac_ldac_n = ldac_n;
`endif

  ups_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
`ifdef UPS_DAC_LDAC_EN
    .extra   (extra),
    .two_left(two_left),
`endif
    .tick    (tick)
  );

  always_comb begin
    launch      = 1'b0;
    launch_word = bus.dac;
    if (state == DTX_IDLE) begin
      launch = bus.dac_dv;
    end else if (launch_slot) begin
      launch = bus.dac_dv || pend_vld;
      if (!bus.dac_dv) launch_word = pend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DTX_IDLE;
      rest     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      bit_cnt  <= '0;
      drop_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
      mosi     <= 1'b0;
`ifdef UPS_DAC_LDAC_EN
      ldac_n   <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      // Any dv outside IDLE that finds a word already waiting loses that word.
      if (bus.dac_dv && pend_vld && state != DTX_IDLE && drop_cnt != '1)
        drop_cnt <= drop_cnt + DROP_W'(1);
      if (launch_slot) begin
        pend_vld <= 1'b0;
      end else if (bus.dac_dv && state != DTX_IDLE) begin
        pend     <= bus.dac;
        pend_vld <= 1'b1;
      end

      case (state)
        DTX_SETUP: if (tick) begin
          state   <= DTX_SHIFT;
          bit_cnt <= '0;
        end
        DTX_SHIFT: if (tick) begin
          if (!sclk) begin
            sclk <= 1'b1;
          end else begin
            sclk <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              state <= DTX_HOLD;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              mosi    <= rest[DATA_W-2];
              rest    <= {rest[DATA_W-3:0], 1'b0};
            end
          end
        end
        DTX_HOLD: if (tick) begin
          state <= DTX_GAP;
          cs_n  <= 1'b1;
          done  <= 1'b1;
          mosi  <= 1'b0;
`ifdef UPS_DAC_LDAC_EN
          ldac_n <= 1'b0;
`endif
        end
        DTX_GAP: begin
`ifdef UPS_DAC_LDAC_EN
          if (two_left) ldac_n <= 1'b1;
`endif
          if (tick && !launch) begin
            state <= DTX_IDLE;
            busy  <= 1'b0;
          end
        end
        default: ;
      endcase

      if (launch) begin
        state <= DTX_SETUP;
        rest  <= launch_word[DATA_W-2:0];
        mosi  <= launch_word[DATA_W-1];
        cs_n  <= 1'b0;
        sclk  <= 1'b0;
        busy  <= 1'b1;
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.drop_cnt = drop_cnt;
  assign bus.dac_sclk = sclk;
  assign bus.dac_cs_n = cs_n;
  assign bus.dac_mosi = mosi;
endmodule

// File: tb/tb_ups_dac_spi_tx.sv
// Bench for ups_dac_spi_tx: frame-offset reference model checked every cycle, plus directed
// scenarios with hand-computed cycle numbers and words.
module tb_ups_dac_spi_tx;
  localparam int D  = 4;
  localparam int W  = 16;
  localparam int DW = 8;
`ifdef UPS_DAC_LDAC_EN
  localparam int G = D + 1;
`else
  localparam int G = D;
`endif
  localparam int CSL = (2 * W + 2) * D;  // frame offset at which cs_n rises
  localparam int FL  = CSL + G;          // frame length including gap

  logic clk = 1'b0;
  logic rst = 1'b0;

  ups_dac_spi_tx_if #(.DATA_W(W), .DROP_W(DW)) bus ();
  ups_dac_spi_tx #(.CLK_DIV(D), .DATA_W(W), .DROP_W(DW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: mk is the offset of the current cycle inside the active frame, -1 when idle.
  int          mk = -1;
  int          mdrop = 0;
  bit          mvalid = 1'b0;
  bit          mpv = 1'b0;
  logic [W-1:0] mword = '0, mpend = '0;

  always @(posedge clk) begin
    if (rst) begin
      mk = -1; mpv = 1'b0; mdrop = 0; mvalid = 1'b1;
    end else if (mvalid) begin
      if (mk < 0) begin
        if (bus.dac_dv) begin mk = 0; mword = bus.dac; end
      end else if (mk == FL - 1) begin
        if (bus.dac_dv) begin
          if (mpv && mdrop < 255) mdrop++;
          mpv = 1'b0; mk = 0; mword = bus.dac;
        end else if (mpv) begin
          mpv = 1'b0; mk = 0; mword = mpend;
        end else begin
          mk = -1;
        end
      end else begin
        if (bus.dac_dv) begin
          if (mpv && mdrop < 255) mdrop++;
          mpend = bus.dac; mpv = 1'b1;
        end
        mk++;
      end
    end
  end

  function automatic logic [3:0] exp_ctl(input int k);
    logic sc;
    sc = (k >= D) && (k < (2 * W + 1) * D) && (((k - D) / D) % 2 == 1);
    return {k >= 0, k == CSL, !(k >= 0 && k < CSL), sc};
  endfunction

  always @(negedge clk) begin
    if (mvalid) begin
      chk("outputs", {bus.busy, bus.done, bus.dac_cs_n, bus.dac_sclk, bus.drop_cnt},
          {exp_ctl(mk), DW'(mdrop)});
      if (mk >= 0 && mk < (2 * W + 1) * D)
        chk("mosi", bus.dac_mosi, mword[W - 1 - ((mk < D) ? 0 : (mk - D) / (2 * D))]);
`ifdef UPS_DAC_LDAC_EN
      chk("ldac_n", bus.dac_ldac_n, !(mk >= CSL && mk < CSL + D - 1));
`endif
    end
  end

  // Pin-level frame decoder, independent of the model.
  logic         prev_cs = 1'b1, prev_sclk = 1'b0, prev_busy = 1'b0;
  logic [W-1:0] cap = '0;
  int           nrise = 0, busy_fall = 0, done_at = 0, done_cnt = 0, ldac_low = 0;
  logic [W-1:0] frames[$];
  int           nrises[$], falls[$], rise_at[$];

  always @(negedge clk) begin
    if (prev_cs && !bus.dac_cs_n) begin falls.push_back(cyc); cap = '0; nrise = 0; end
    if (!bus.dac_cs_n && bus.dac_sclk && !prev_sclk) begin
      cap = {cap[W-2:0], bus.dac_mosi};
      nrise++;
    end
    if (!prev_cs && bus.dac_cs_n) begin
      frames.push_back(cap); nrises.push_back(nrise); rise_at.push_back(cyc);
    end
    if (bus.done) begin done_at = cyc; done_cnt++; end
    if (prev_busy && !bus.busy) busy_fall = cyc;
`ifdef UPS_DAC_LDAC_EN
    if (!bus.dac_ldac_n) ldac_low++;
`endif
    prev_cs = bus.dac_cs_n; prev_sclk = bus.dac_sclk; prev_busy = bus.busy;
  end

  task automatic clear_mon();
    @(negedge clk);
    frames.delete(); nrises.delete(); falls.delete(); rise_at.delete();
    done_cnt = 0; ldac_low = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    clear_mon();
  endtask

  task automatic send(input logic [W-1:0] w, output int at);
    @(negedge clk); bus.dac = w; bus.dac_dv = 1'b1; at = cyc;
    @(negedge clk); bus.dac_dv = 1'b0;
  endtask

  task automatic send_at(input logic [W-1:0] w, input int tgt);
    int dummy;
    while (cyc < tgt - 1) @(negedge clk);
    send(w, dummy);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((bus.busy || mk >= 0) && n < 3000);
    chk("idle_timeout", n >= 3000, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c, c2;
    bus.dac = '0; bus.dac_dv = 1'b0;

    // Single word
    do_reset();
    chk("reset_state", {bus.busy, bus.done, bus.dac_cs_n, bus.dac_sclk, bus.dac_mosi, bus.drop_cnt},
        13'b0_0100_0000_0000);
    send(16'hA55A, c);
    wait_idle();
    chk("t1_nframes", frames.size(), 1);
    if (frames.size() == 1) begin
      chk("t1_word", frames[0], 16'hA55A);
      chk("t1_sclk_rises", nrises[0], 16);
      chk("t1_cs_fall", falls[0], c + 1);
      chk("t1_cs_rise", rise_at[0], c + 137);
    end
    chk("t1_done", done_at, c + 137);
    chk("t1_busy_fall", busy_fall, c + 137 + G);

    // Two words, second queued while the first is on the wire
    do_reset();
    send(16'h1234, c);
    send_at(16'h5678, c + 10);
    wait_idle();
    chk("t2_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("t2_word0", frames[0], 16'h1234);
      chk("t2_word1", frames[1], 16'h5678);
      chk("t2_gap", falls[1] - rise_at[0], G);
    end
    chk("t2_drop", bus.drop_cnt, 8'd0);

    // Three words in one frame: middle one is overwritten
    do_reset();
    send(16'h1111, c);
    send_at(16'h2222, c + 5);
    send_at(16'h3333, c + 10);
    wait_idle();
    chk("t3_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("t3_word0", frames[0], 16'h1111);
      chk("t3_word1", frames[1], 16'h3333);
    end
    chk("t3_drop", bus.drop_cnt, 8'd1);

    // dv on the last gap cycle while a word is pending
    do_reset();
    send(16'hBEEF, c);
    send_at(16'h0101, c + 10);
    send_at(16'hCAFE, c + 136 + G);
    wait_idle();
    chk("t4_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("t4_word1", frames[1], 16'hCAFE);
      chk("t4_no_idle", falls[1], c + 137 + G);
    end
    chk("t4_drop", bus.drop_cnt, 8'd1);

    // Reset in the middle of bit 7
    do_reset();
    send(16'hC3A5, c);
    while (cyc < c + 63) @(negedge clk);
    chk("t5_mid_frame", {bus.dac_cs_n, bus.busy}, 2'b01);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t5_after_rst", {bus.busy, bus.done, bus.dac_cs_n, bus.dac_sclk}, 4'b0010);
    chk("t5_no_done", done_cnt, 0);
    clear_mon();
    send(16'h0F0F, c2);
    wait_idle();
    chk("t5_nframes", frames.size(), 1);
    if (frames.size() == 1) chk("t5_word", frames[0], 16'h0F0F);

    // Flood of dv saturates the drop counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); bus.dac = 16'(i * 37); bus.dac_dv = 1'b1;
    end
    @(negedge clk); bus.dac_dv = 1'b0;
    wait_idle();
    chk("t6_drop_sat", bus.drop_cnt, 8'hFF);
`ifdef UPS_DAC_LDAC_EN
    chk("t6_ldac_cycles", ldac_low, 3 * frames.size());
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end
endmodule
